// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction queue carrying instruction word and PC
// Circular buffer with separate occupancy counter; storage is never reset, only pointers and count.
module inst_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  input  logic            flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            ready_en;
  logic            push;
  logic            pop;

  logic [31:0]     mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];

  // ready_en keeps in_ready low until the first edge after reset release
  assign in_ready  = ready_en && (count_q < CW'(DEPTH)) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;
  assign out_inst  = mem_inst[rd_ptr];
  assign out_pc    = mem_pc[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= in_inst;
      mem_pc[wr_ptr]   <= in_pc;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - scoreboard bench for inst_queue
module tb_inst_queue;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_inst = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic            flush = 1'b0;
  logic [2:0]      count;

  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  bit   started = 0;

  inst_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model advances on the same edge as the DUT, from the bench's own state
  task automatic tick();
    bit p;
    bit o;
    @(posedge clk);
    if (rst) begin
      q.delete();
      started = 0;
    end else begin
      p = started && in_valid && (q.size() < DEPTH) && !flush;
      o = (q.size() > 0) && out_ready && !flush;
      if (flush) q.delete();
      else begin
        if (o) void'(q.pop_front());
        if (p) q.push_back('{inst: in_inst, pc: in_pc});
      end
      started = 1;
    end
    #1;
  endtask

  task automatic push_word(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready: got %b want 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_first_edge_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fill();
    logic [31:0] insts [4];
    insts[0] = 32'h0000_0013; insts[1] = 32'h0010_0093;
    insts[2] = 32'h0020_0113; insts[3] = 32'h0030_0193;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = insts[i]; in_pc = 64'h8000_0000 + 64'(4 * i);
      if (i == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_no_bypass: got %b want 0", out_valid); end
      end
      tick();
      checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL fill_count_%0d: got %0d want %0d", i, count, q.size()); end
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    checks++; if (out_inst !== q[0].inst) begin errors++; $display("FAIL fill_out_inst: got %h want %h", out_inst, q[0].inst); end
    checks++; if (out_pc !== q[0].pc) begin errors++; $display("FAIL fill_out_pc: got %h want %h", out_pc, q[0].pc); end
    in_valid = 1'b1; in_inst = 32'hDEAD_0001; in_pc = 64'h1;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL full_ignore_count: got %0d want %0d", count, q.size()); end
    checks++; if (out_inst !== q[0].inst) begin errors++; $display("FAIL full_hold_inst: got %h want %h", out_inst, q[0].inst); end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    while (q.size() > 0) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid: got %b want 1", out_valid); end
      checks++; if (out_inst !== q[0].inst) begin errors++; $display("FAIL drain_inst: got %h want %h", out_inst, q[0].inst); end
      checks++; if (out_pc !== q[0].pc) begin errors++; $display("FAIL drain_pc: got %h want %h", out_pc, q[0].pc); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid: got %b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_empty_count: got %0d want 0", count); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_pop_count: got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + 32'(i), 64'h9000_0000 + 64'(4 * i));
    in_valid = 1'b1; in_inst = 32'hDEAD_BEEF; in_pc = 64'hBAD; out_ready = 1'b1;
    checks++; if (out_inst !== q[0].inst) begin errors++; $display("FAIL fullpop_head: got %h want %h", out_inst, q[0].inst); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL fullpop_count: got %0d want %0d", count, q.size()); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_ready: got %b want 1", in_ready); end
    test_drain();
  endtask

  task automatic test_back_to_back();
    push_word(32'h0000_1000, 64'h100);
    push_word(32'h0000_1001, 64'h104);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      in_inst = 32'h0000_1000 + 32'(i); in_pc = 64'h100 + 64'(4 * i);
      checks++; if (out_inst !== q[0].inst) begin errors++; $display("FAIL b2b_inst_%0d: got %h want %h", i, out_inst, q[0].inst); end
      tick();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count_%0d: got %0d want 2", i, count); end
    end
    in_valid = 1'b0;
    test_drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push_word(32'hC000_0000 + 32'(i), 64'hC0 + 64'(4 * i));
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'hBAD0_0001; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    push_word(32'h0000_0077, 64'h77);
    checks++; if (out_inst !== q[0].inst) begin errors++; $display("FAIL flush_next_inst: got %h want %h", out_inst, q[0].inst); end
    test_drain();
  endtask

  task automatic test_async_reset();
    push_word(32'hE000_0000, 64'hE0);
    push_word(32'hE000_0001, 64'hE4);
    #3;
    rst = 1'b1;
    q.delete();
    started = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL areset_count: got %0d want 0", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_ready: got %b want 0", in_ready); end
    #2;
    rst = 1'b0;
    tick();
    push_word(32'h0000_0055, 64'h55);
    checks++; if (out_inst !== q[0].inst) begin errors++; $display("FAIL areset_new_inst: got %h want %h", out_inst, q[0].inst); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL areset_new_count: got %0d want 1", count); end
    test_drain();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_pop();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter XLEN, 64, width of the PC field carried with each instruction.
REQ-002 Parameter DEPTH, 4, number of entries; SHALL be a power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  fetch side presents an instruction.
REQ-006 in_ready  output  1  queue accepts an entry this cycle.
REQ-007 in_inst  input  32  fetched instruction word.
REQ-008 in_pc  input  XLEN  PC of in_inst.
REQ-009 out_valid  output  1  head entry is presented to the decode unit.
REQ-010 out_ready  input  1  decode unit consumes the head this cycle.
REQ-011 out_inst  output  32  head instruction word.
REQ-012 out_pc  output  XLEN  head PC.
REQ-013 flush  input  1  branch/exception redirect; discard all entries.
REQ-014 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 Push SHALL occur iff in_valid && in_ready && !flush; entry written at wr_ptr, then wr_ptr increments.
REQ-016 Pop SHALL occur iff out_valid && out_ready && !flush; rd_ptr increments.
REQ-017 wr_ptr and rd_ptr SHALL be $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-018 in_ready SHALL be 1 iff count < DEPTH and flush is 0; no combinational path from out_ready to in_ready.
REQ-019 out_valid SHALL be 1 iff count != 0; out_inst/out_pc SHALL be the entry at rd_ptr, registered storage only (no in_* to out_* bypass).
REQ-020 Latency: an entry pushed in cycle N SHALL appear at the outputs no earlier than cycle N+1.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 count SHALL be incremented by push-only, decremented by pop-only, and never exceed DEPTH or underflow.
REQ-023 When full, in_ready=0 and in_valid SHALL be ignored even if out_ready=1 in the same cycle.
REQ-024 When empty, out_valid=0 and out_ready SHALL be ignored.
REQ-025 flush SHALL, at the next rising edge, set count=0 and wr_ptr=rd_ptr=0; push and pop requested in the flush cycle SHALL be discarded.
REQ-026 Entries SHALL be delivered in strict FIFO order; out_inst/out_pc SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 Storage contents SHALL not be reset; only pointers and count are.

Reset
REQ-028 rst asserted SHALL immediately (without clock) force count=0, wr_ptr=rd_ptr=0, out_valid=0, in_ready=0.
REQ-029 While rst is high in_ready SHALL stay 0; after rst deasserts, in_ready SHALL be 1 from the first rising edge onward.
REQ-030 rst asserted mid-operation SHALL discard all entries; no entry pushed before reset SHALL be presented afterwards.

Verification
REQ-031 Fill: push 0x00000013@pc 0x80000000, 0x00100093@0x80000004, 0x00200113@0x80000008, 0x00300193@0x8000000C with out_ready=0 -> count=4, in_ready=0, out_inst=0x00000013, out_pc=0x80000000.
REQ-032 Drain in order: from full, out_ready=1 for 4 cycles -> out_inst sequence 0x00000013,0x00100093,0x00200113,0x00300193, then out_valid=0, count=0.
REQ-033 Simultaneous: count=2, in_valid=1 and out_ready=1 for 10 cycles with incrementing inst -> count stays 2, pointers wrap, output order matches input order.
REQ-034 Flush: count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, neither pushed word ever appears at output.
REQ-035 Full-plus-pop: count=4, in_valid=1, out_ready=1 -> count=3, pushed word not stored; next cycle in_ready=1.
REQ-036 Async reset: rst pulsed between clock edges at count=2 -> out_valid=0 and count=0 before the next edge.
